// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operation sequencer.
// Holds the sequencer state encoding and the one-hot ALU register-load strobes.
// No ports; imported by the sequencer RTL.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    LOAD_B,
    LOAD_D,
    LOAD_E,
    RUN
  } state_t;

  // One-hot load strobes for the ALU b, d and e coefficient registers.
  localparam logic [2:0] REG_EN_NONE = 3'b000;
  localparam logic [2:0] REG_EN_B    = 3'b001;
  localparam logic [2:0] REG_EN_D    = 3'b010;
  localparam logic [2:0] REG_EN_E    = 3'b100;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Bundle of every sequencer signal except clk/rst: command, sample stream,
// ALU control/operand bus and result stream.
// slave = sequencer view, master = environment view (command source, sample
// source, external ALU and result sink).
interface alu_op_sequencer_if #(
  parameter int BUS_WIDTH = 8,
  parameter int CNT_WIDTH = 16
);

  // Command channel
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [BUS_WIDTH-1:0] cmd_coef_b;
  logic [BUS_WIDTH-1:0] cmd_coef_d;
  logic [BUS_WIDTH-1:0] cmd_coef_e;
  logic [CNT_WIDTH-1:0] cmd_count;

  // Sample stream
  logic                 s_valid;
  logic                 s_ready;
  logic [BUS_WIDTH-1:0] s_a;
  logic [BUS_WIDTH-1:0] s_b;

  // ALU control and operands
  logic [BUS_WIDTH-1:0] alu_imm;
  logic [2:0]           alu_reg_en;
  logic                 alu_f_clr;
  logic [BUS_WIDTH-1:0] alu_data_a;
  logic [BUS_WIDTH-1:0] alu_data_b;
  logic [BUS_WIDTH-1:0] alu_result;

  // Result stream and completion
  logic                 m_valid;
  logic                 m_ready;
  logic [BUS_WIDTH-1:0] m_result;
  logic                 done;

  modport slave (
    input  cmd_valid, cmd_coef_b, cmd_coef_d, cmd_coef_e, cmd_count,
    input  s_valid, s_a, s_b, alu_result, m_ready,
    output cmd_ready, s_ready, alu_imm, alu_reg_en, alu_f_clr,
    output alu_data_a, alu_data_b, m_valid, m_result, done
  );

  modport master (
    output cmd_valid, cmd_coef_b, cmd_coef_d, cmd_coef_e, cmd_count,
    output s_valid, s_a, s_b, alu_result, m_ready,
    input  cmd_ready, s_ready, alu_imm, alu_reg_en, alu_f_clr,
    input  alu_data_a, alu_data_b, m_valid, m_result, done
  );

endinterface

// File: rtl/alu_op_sequencer.sv
// Purpose: per command, clear the ALU, load its b/d/e coefficients, then stream
//   cmd_count samples through it into a one-entry registered result slot.
// Latency: 4 setup cycles after command accept; result valid 1 cycle after sample accept.
// Backpressure: s_ready = !m_valid || m_ready in RUN, so a stalled result stalls samples.
// Ports: clk, rst (sync, active-high), bus (alu_op_sequencer_if.slave).
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int BUS_WIDTH = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  alu_op_sequencer_if.slave      bus
);

  state_t               state;
  logic [BUS_WIDTH-1:0] coef_b;
  logic [BUS_WIDTH-1:0] coef_d;
  logic [BUS_WIDTH-1:0] coef_e;
  logic [CNT_WIDTH-1:0] remaining;

  logic [BUS_WIDTH-1:0] alu_imm_q;
  logic [2:0]           alu_reg_en_q;
  logic                 alu_f_clr_q;
  logic                 m_valid_q;
  logic [BUS_WIDTH-1:0] m_result_q;

  logic                 in_run;
  logic                 s_ready_c;
  logic                 accept;

  always_comb begin
    in_run    = (state == RUN);
    s_ready_c = in_run && (!m_valid_q || bus.m_ready);
    accept    = s_ready_c && bus.s_valid;
  end

  assign bus.cmd_ready  = (state == IDLE);
  assign bus.s_ready    = s_ready_c;
  assign bus.alu_data_a = in_run ? bus.s_a : '0;
  assign bus.alu_data_b = in_run ? bus.s_b : '0;
  assign bus.alu_imm    = alu_imm_q;
  assign bus.alu_reg_en = alu_reg_en_q;
  assign bus.alu_f_clr  = alu_f_clr_q;
  assign bus.m_valid    = m_valid_q;
  assign bus.m_result   = m_result_q;

  // done has to coincide with the final sample accept, which depends on
  // s_valid in the same cycle, so it cannot come from a register.
  assign bus.done = ((state == LOAD_E) && (remaining == '0)) ||
                    (accept && (remaining == CNT_WIDTH'(1)));

  // ALU control outputs are registered: each is loaded on the edge that
  // enters the state it belongs to, so it is valid for that whole state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      coef_b       <= '0;
      coef_d       <= '0;
      coef_e       <= '0;
      remaining    <= '0;
      alu_imm_q    <= '0;
      alu_reg_en_q <= REG_EN_NONE;
      alu_f_clr_q  <= 1'b0;
      m_valid_q    <= 1'b0;
      m_result_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            coef_b      <= bus.cmd_coef_b;
            coef_d      <= bus.cmd_coef_d;
            coef_e      <= bus.cmd_coef_e;
            remaining   <= bus.cmd_count;
            alu_f_clr_q <= 1'b1;
            state       <= CLR;
          end
        end
        CLR: begin
          alu_f_clr_q  <= 1'b0;
          alu_imm_q    <= coef_b;
          alu_reg_en_q <= REG_EN_B;
          state        <= LOAD_B;
        end
        LOAD_B: begin
          alu_imm_q    <= coef_d;
          alu_reg_en_q <= REG_EN_D;
          state        <= LOAD_D;
        end
        LOAD_D: begin
          alu_imm_q    <= coef_e;
          alu_reg_en_q <= REG_EN_E;
          state        <= LOAD_E;
        end
        LOAD_E: begin
          alu_imm_q    <= '0;
          alu_reg_en_q <= REG_EN_NONE;
          state        <= (remaining == '0) ? IDLE : RUN;
        end
        RUN: begin
          if (accept) begin
            remaining <= remaining - CNT_WIDTH'(1);
            if (remaining == CNT_WIDTH'(1)) begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // The result slot is independent of the command FSM so a pending
      // result outlives the command that produced it.
      if (accept) begin
        m_valid_q  <= 1'b1;
        m_result_q <= bus.alu_result;
      end else if (bus.m_ready) begin
        m_valid_q  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: directed scenarios plus randomized traffic,
// every cycle compared against a queue-based reference model.
// The model expands each accepted command into a list of expected ALU control
// words, then counts samples down and tracks the single result slot.
module tb_alu_op_sequencer;

  localparam int BW = 8;
  localparam int CW = 16;

  typedef struct packed {
    logic          clr;
    logic [2:0]    en;
    logic [BW-1:0] imm;
    logic          done;
  } ctl_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_op_sequencer_if #(.BUS_WIDTH(BW), .CNT_WIDTH(CW)) bus ();

  alu_op_sequencer #(.BUS_WIDTH(BW), .CNT_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Stand-in ALU: adds its two operands.
  assign bus.alu_result = bus.alu_data_a + bus.alu_data_b;

  ctl_t          ctl_q[$];
  int            run_left;
  logic          exp_mv;
  logic [BW-1:0] exp_mres;
  logic [BW-1:0] got_q[$];
  int            checks = 0;
  int            errors = 0;
  int            done_seen = 0;
  int            acc_cnt = 0;
  bit            cmd_taken;

  function automatic ctl_t mk(input logic c, input logic [2:0] e, input logic [BW-1:0] i,
                              input logic d);
    ctl_t w;
    w.clr = c; w.en = e; w.imm = i; w.done = d;
    return w;
  endfunction

  function automatic bit busy();
    return (ctl_q.size() > 0) || (run_left > 0);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ctl_q.delete();
    run_left = 0;
    exp_mv   = 1'b0;
    exp_mres = '0;
  endtask

  // One clock: compare outputs at the falling edge, advance the model at the rising edge.
  task automatic step();
    bit   setup, run, srdy, acc;
    ctl_t w;
    logic dn;
    @(negedge clk);
    setup = (ctl_q.size() > 0);
    run   = !setup && (run_left > 0);
    srdy  = run && (!exp_mv || bus.m_ready);
    acc   = srdy && bus.s_valid;
    w     = setup ? ctl_q[0] : '0;
    dn    = setup ? w.done : (acc && (run_left == 1));
    chk("cmd_ready",  32'(bus.cmd_ready),  32'(!setup && !run));
    chk("alu_f_clr",  32'(bus.alu_f_clr),  32'(w.clr));
    chk("alu_reg_en", 32'(bus.alu_reg_en), 32'(w.en));
    chk("alu_imm",    32'(bus.alu_imm),    32'(w.imm));
    chk("s_ready",    32'(bus.s_ready),    32'(srdy));
    chk("alu_data_a", 32'(bus.alu_data_a), run ? 32'(bus.s_a) : 32'(0));
    chk("alu_data_b", 32'(bus.alu_data_b), run ? 32'(bus.s_b) : 32'(0));
    chk("done",       32'(bus.done),       32'(dn));
    chk("m_valid",    32'(bus.m_valid),    32'(exp_mv));
    chk("m_result",   32'(bus.m_result),   32'(exp_mres));
    if (bus.done === 1'b1) done_seen++;
    if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) got_q.push_back(bus.m_result);
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (setup) w = ctl_q.pop_front();
      else if (acc) run_left--;
      if (acc) begin
        exp_mv   = 1'b1;
        exp_mres = bus.s_a + bus.s_b;
        acc_cnt++;
      end else if (bus.m_ready) begin
        exp_mv = 1'b0;
      end
      if (!setup && !run && bus.cmd_valid) begin
        ctl_q.push_back(mk(1'b1, 3'b000, '0, 1'b0));
        ctl_q.push_back(mk(1'b0, 3'b001, bus.cmd_coef_b, 1'b0));
        ctl_q.push_back(mk(1'b0, 3'b010, bus.cmd_coef_d, 1'b0));
        ctl_q.push_back(mk(1'b0, 3'b100, bus.cmd_coef_e, bus.cmd_count == '0));
        run_left  = int'(bus.cmd_count);
        cmd_taken = 1'b1;
      end
    end
    #1;
  endtask

  task automatic drive_rand(input int pv, input int pr);
    bus.s_valid = ($urandom_range(0, 99) < pv);
    bus.m_ready = ($urandom_range(0, 99) < pr);
    bus.s_a     = BW'($urandom);
    bus.s_b     = BW'($urandom);
  endtask

  // Offer a command until accepted; pv < 0 leaves the stream inputs untouched.
  task automatic issue(input logic [BW-1:0] b, input logic [BW-1:0] d, input logic [BW-1:0] e,
                       input logic [CW-1:0] n, input int pv, input int pr);
    int g = 0;
    bus.cmd_coef_b = b; bus.cmd_coef_d = d; bus.cmd_coef_e = e; bus.cmd_count = n;
    bus.cmd_valid  = 1'b1;
    cmd_taken      = 1'b0;
    while (!cmd_taken && g < 300) begin
      if (pv >= 0) drive_rand(pv, pr);
      step();
      g++;
    end
    bus.cmd_valid = 1'b0;
    chk("cmd_accept_bound", 32'(cmd_taken), 32'(1));
  endtask

  task automatic run_to_idle(input int pv, input int pr, input int limit);
    int g = 0;
    while (busy() && g < limit) begin
      if (pv >= 0) drive_rand(pv, pr);
      step();
      g++;
    end
    chk("idle_bound", 32'(busy()), 32'(0));
  endtask

  task automatic drain();
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    step();
    step();
  endtask

  initial begin
    int d0, base, g;
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_coef_b = '0; bus.cmd_coef_d = '0; bus.cmd_coef_e = '0;
    bus.cmd_count = '0; bus.s_valid = 1'b0; bus.s_a = '0; bus.s_b = '0; bus.m_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    step();
    step();
    rst = 1'b0;
    step();

    // Zero-count command: clear, three loads, done alongside the e load, no sample handshake.
    d0 = done_seen;
    bus.s_valid = 1'b1;
    issue(8'd3, 8'd2, 8'd5, 16'd0, -1, 0);
    run_to_idle(-1, 0, 20);
    chk("t037_done_count", 32'(done_seen - d0), 32'(1));
    bus.s_valid = 1'b0;
    step();

    // Four samples at full flow, (k,k) -> 2k.
    d0 = done_seen; got_q.delete(); base = acc_cnt;
    bus.s_valid = 1'b1; bus.m_ready = 1'b1;
    issue(8'd1, 8'd1, 8'd1, 16'd4, -1, 0);
    g = 0;
    while (busy() && g < 50) begin
      bus.s_a = BW'(acc_cnt - base + 1);
      bus.s_b = BW'(acc_cnt - base + 1);
      step();
      g++;
    end
    drain();
    chk("t038_result_count", 32'(got_q.size()), 32'(4));
    for (int i = 0; i < got_q.size() && i < 4; i++) chk("t038_result", 32'(got_q[i]), 32'(2 * (i + 1)));
    chk("t038_done_count", 32'(done_seen - d0), 32'(1));

    // Result held under m_ready=0; second sample enters on the draining cycle.
    d0 = done_seen; got_q.delete();
    bus.s_valid = 1'b1; bus.m_ready = 1'b0; bus.s_a = 8'd1; bus.s_b = 8'd1;
    issue(8'd7, 8'd7, 8'd7, 16'd2, -1, 0);
    repeat (8) step();
    bus.m_ready = 1'b1; bus.s_a = 8'd2; bus.s_b = 8'd2;
    run_to_idle(-1, 0, 20);
    drain();
    chk("t039_result_count", 32'(got_q.size()), 32'(2));
    if (got_q.size() == 2) begin
      chk("t039_first",  32'(got_q[0]), 32'(2));
      chk("t039_second", 32'(got_q[1]), 32'(4));
    end
    chk("t039_done_count", 32'(done_seen - d0), 32'(1));

    // Reset after one of three samples: no done, next command taken in the first cycle.
    d0 = done_seen;
    bus.s_valid = 1'b0; bus.m_ready = 1'b0;
    issue(8'hA1, 8'hB2, 8'hC3, 16'd3, -1, 0);
    repeat (4) step();
    bus.s_valid = 1'b1; bus.s_a = 8'd10; bus.s_b = 8'd20;
    step();
    bus.s_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t040_no_done", 32'(done_seen - d0), 32'(0));
    bus.cmd_coef_b = 8'h0B; bus.cmd_coef_d = 8'h0D; bus.cmd_coef_e = 8'h0E; bus.cmd_count = 16'd1;
    bus.cmd_valid = 1'b1; cmd_taken = 1'b0;
    step();
    bus.cmd_valid = 1'b0;
    chk("t040_immediate_accept", 32'(cmd_taken), 32'(1));
    run_to_idle(80, 80, 100);
    drain();

    // Command offered mid-run waits for IDLE, then loads its own coefficients.
    bus.s_valid = 1'b0;
    issue(8'h11, 8'h22, 8'h33, 16'd3, -1, 0);
    issue(8'h44, 8'h55, 8'h66, 16'd2, 60, 70);
    run_to_idle(60, 70, 200);
    drain();

    // Randomized commands with random flow control and occasional resets.
    for (int c = 0; c < 25; c++) begin
      issue(BW'($urandom), BW'($urandom), BW'($urandom), CW'($urandom_range(0, 6)), 50, 50);
      g = 0;
      while (busy() && g < 300) begin
        drive_rand(60, 50);
        rst = ($urandom_range(0, 59) == 0);
        step();
        g++;
      end
      rst = 1'b0;
      chk("rand_idle_bound", 32'(busy()), 32'(0));
    end
    drain();

    // Maximum count, continuous flow, no wrap.
    d0 = done_seen; got_q.delete();
    bus.s_valid = 1'b1; bus.m_ready = 1'b1;
    issue(8'd1, 8'd2, 8'd3, 16'hFFFF, -1, 0);
    g = 0;
    while (busy() && g < 70000) begin
      bus.s_a = BW'($urandom);
      bus.s_b = BW'($urandom);
      step();
      g++;
    end
    chk("t042_idle_bound", 32'(busy()), 32'(0));
    drain();
    chk("t042_result_count", 32'(got_q.size()), 32'(65535));
    chk("t042_done_count", 32'(done_seen - d0), 32'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
